// File: rtl/ycbcr_thresh_ctrl.sv
// Threshold shadow/commit controller and per-frame mask statistics for the YCbCr skin-mask stage.
// Thresholds and published results change only at the frame-boundary commit cycle.
module ycbcr_thresh_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_wr_en,
    input  logic [2:0]  cfg_addr,
    input  logic [7:0]  cfg_wdata,
    input  logic        per_frame_vsync,
    input  logic        per_frame_href,
    input  logic        per_frame_clken,
    input  logic        mask_in,
    output logic [7:0]  cb_min,
    output logic [7:0]  cb_max,
    output logic [7:0]  cr_min,
    output logic [7:0]  cr_max,
    output logic [19:0] hit_cnt,
    output logic [9:0]  bbox_x_min,
    output logic [9:0]  bbox_x_max,
    output logic [9:0]  bbox_y_min,
    output logic [9:0]  bbox_y_max,
    output logic        bbox_valid,
    output logic        frame_done,
    output logic        cfg_pending
);

    localparam logic [7:0] CB_MIN_RST = 8'd179;
    localparam logic [7:0] CB_MAX_RST = 8'd255;
    localparam logic [7:0] CR_MIN_RST = 8'd97;
    localparam logic [7:0] CR_MAX_RST = 8'd108;
    localparam logic [9:0] COORD_MAX  = 10'd1023;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FRAME, S_COMMIT} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        enable;
    logic        prev_frame;
    logic [7:0]  cb_min_sh;
    logic [7:0]  cb_max_sh;
    logic [7:0]  cr_min_sh;
    logic [7:0]  cr_max_sh;
    logic        vs_d;
    logic        href_d;
    logic [9:0]  x_cnt;
    logic [9:0]  y_cnt;
    logic [19:0] acc_cnt;
    logic [9:0]  acc_x_min;
    logic [9:0]  acc_x_max;
    logic [9:0]  acc_y_min;
    logic [9:0]  acc_y_max;

    logic        frame_start;
    logic        href_fall;
    logic        commit;
    logic        publish;
    logic        pix_vld;
    logic        pix_hit;
    logic        acc_clr;
    logic        in_frame;

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    function automatic logic [19:0] sat_inc20(input logic [19:0] v);
        return (v == 20'hFFFFF) ? v : v + 20'd1;
    endfunction

    assign frame_start = per_frame_vsync & ~vs_d;
    assign href_fall   = href_d & ~per_frame_href;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            prev_frame <= 1'b0;
        end else begin
            state      <= state_nxt;
            prev_frame <= (state == S_FRAME);
        end
    end

    // FSM: next state; clearing enable wins from every state
    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   state_nxt = S_WAIT;
                S_WAIT:   if (frame_start) state_nxt = S_COMMIT;
                S_FRAME:  if (frame_start) state_nxt = S_COMMIT;
                S_COMMIT: state_nxt = S_FRAME;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    // FSM: decoded controls
    always_comb begin
        commit   = (state == S_COMMIT);
        in_frame = (state == S_FRAME);
        publish  = commit & prev_frame;
        acc_clr  = commit | (state == S_IDLE);
        pix_vld  = in_frame & per_frame_clken & per_frame_href;
        pix_hit  = pix_vld & mask_in;
    end

    // Config: shadow written by the host, active copied only at commit.
    // A write in the commit cycle lands after the copy and stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cb_min_sh   <= CB_MIN_RST;
            cb_max_sh   <= CB_MAX_RST;
            cr_min_sh   <= CR_MIN_RST;
            cr_max_sh   <= CR_MAX_RST;
            cb_min      <= CB_MIN_RST;
            cb_max      <= CB_MAX_RST;
            cr_min      <= CR_MIN_RST;
            cr_max      <= CR_MAX_RST;
            enable      <= 1'b0;
            cfg_pending <= 1'b0;
        end else begin
            if (commit) begin
                cb_min <= cb_min_sh;
                cb_max <= cb_max_sh;
                cr_min <= cr_min_sh;
                cr_max <= cr_max_sh;
            end
            if (cfg_wr_en) begin
                case (cfg_addr)
                    3'd0:    cb_min_sh <= cfg_wdata;
                    3'd1:    cb_max_sh <= cfg_wdata;
                    3'd2:    cr_min_sh <= cfg_wdata;
                    3'd3:    cr_max_sh <= cfg_wdata;
                    3'd4:    enable    <= cfg_wdata[0];
                    default: ;
                endcase
            end
            if (cfg_wr_en && (cfg_addr <= 3'd3))
                cfg_pending <= 1'b1;
            else if (commit)
                cfg_pending <= 1'b0;
        end
    end

    // Frame timing edge detectors and pixel coordinates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d   <= 1'b0;
            href_d <= 1'b0;
            x_cnt  <= '0;
            y_cnt  <= '0;
        end else begin
            vs_d   <= per_frame_vsync;
            href_d <= per_frame_href;
            if (in_frame) begin
                if (href_fall) begin
                    x_cnt <= '0;
                    y_cnt <= sat_inc10(y_cnt);
                end else if (pix_vld) begin
                    x_cnt <= sat_inc10(x_cnt);
                end
            end else if (acc_clr) begin
                x_cnt <= '0;
                y_cnt <= '0;
            end
        end
    end

    // Hit accumulators use pre-increment coordinates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt   <= '0;
            acc_x_min <= COORD_MAX;
            acc_x_max <= '0;
            acc_y_min <= COORD_MAX;
            acc_y_max <= '0;
        end else if (acc_clr) begin
            acc_cnt   <= '0;
            acc_x_min <= COORD_MAX;
            acc_x_max <= '0;
            acc_y_min <= COORD_MAX;
            acc_y_max <= '0;
        end else if (pix_hit) begin
            acc_cnt <= sat_inc20(acc_cnt);
            if (x_cnt < acc_x_min) acc_x_min <= x_cnt;
            if (x_cnt > acc_x_max) acc_x_max <= x_cnt;
            if (y_cnt < acc_y_min) acc_y_min <= y_cnt;
            if (y_cnt > acc_y_max) acc_y_max <= y_cnt;
        end
    end

    // Published results of the last completed frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt    <= '0;
            bbox_x_min <= COORD_MAX;
            bbox_x_max <= '0;
            bbox_y_min <= COORD_MAX;
            bbox_y_max <= '0;
            bbox_valid <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= publish;
            if (publish) begin
                hit_cnt    <= acc_cnt;
                bbox_x_min <= acc_x_min;
                bbox_x_max <= acc_x_max;
                bbox_y_min <= acc_y_min;
                bbox_y_max <= acc_y_max;
                bbox_valid <= (acc_cnt != 20'd0);
            end
        end
    end

endmodule

// File: tb/tb_ycbcr_thresh_ctrl.sv
// Bench for ycbcr_thresh_ctrl: table of 16x8 frames with config writes, scoreboard of
// per-frame results checked on frame_done, plus commit-cycle write, disable and reset sequences.
module tb_ycbcr_thresh_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cfg_wr_en;
    logic [2:0]  cfg_addr;
    logic [7:0]  cfg_wdata;
    logic        per_frame_vsync;
    logic        per_frame_href;
    logic        per_frame_clken;
    logic        mask_in;
    logic [7:0]  cb_min;
    logic [7:0]  cb_max;
    logic [7:0]  cr_min;
    logic [7:0]  cr_max;
    logic [19:0] hit_cnt;
    logic [9:0]  bbox_x_min;
    logic [9:0]  bbox_x_max;
    logic [9:0]  bbox_y_min;
    logic [9:0]  bbox_y_max;
    logic        bbox_valid;
    logic        frame_done;
    logic        cfg_pending;

    ycbcr_thresh_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_wr_en       (cfg_wr_en),
        .cfg_addr        (cfg_addr),
        .cfg_wdata       (cfg_wdata),
        .per_frame_vsync (per_frame_vsync),
        .per_frame_href  (per_frame_href),
        .per_frame_clken (per_frame_clken),
        .mask_in         (mask_in),
        .cb_min          (cb_min),
        .cb_max          (cb_max),
        .cr_min          (cr_min),
        .cr_max          (cr_max),
        .hit_cnt         (hit_cnt),
        .bbox_x_min      (bbox_x_min),
        .bbox_x_max      (bbox_x_max),
        .bbox_y_min      (bbox_y_min),
        .bbox_y_max      (bbox_y_max),
        .bbox_valid      (bbox_valid),
        .frame_done      (frame_done),
        .cfg_pending     (cfg_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] cnt;
        logic [9:0]  xmin;
        logic [9:0]  xmax;
        logic [9:0]  ymin;
        logic [9:0]  ymax;
        logic        valid;
    } res_t;

    typedef struct {
        int          mode;
        int          ax;
        int          ay;
        int          bx;
        int          by;
        logic [2:0]  addr;
        logic [7:0]  data;
        logic [7:0]  e_cbmin;
        logic [7:0]  e_cbmax;
        logic [7:0]  e_crmin;
        logic [7:0]  e_crmax;
    } vec_t;

    res_t sb[$];
    res_t mon_r;
    vec_t vecs[7];
    int   n_cmp;
    int   n_fail;
    int   n_done;
    logic [7:0] cur_cbmin, cur_cbmax, cur_crmin, cur_crmax;
    int   done_ref;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // mode 0: no hits, 1: point a, 2: points a and b, 3: every pixel
    function automatic logic is_hit(input int mode, input int ax, input int ay,
                                    input int bx, input int by, input int x, input int y);
        case (mode)
            1:       return (x == ax && y == ay);
            2:       return (x == ax && y == ay) || (x == bx && y == by);
            3:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic res_t model(input int mode, input int ax, input int ay,
                                   input int bx, input int by);
        res_t r;
        r.cnt = 20'd0; r.xmin = 10'd1023; r.xmax = 10'd0; r.ymin = 10'd1023; r.ymax = 10'd0;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 16; x++)
                if (is_hit(mode, ax, ay, bx, by, x, y)) begin
                    r.cnt = r.cnt + 20'd1;
                    if (x < int'(r.xmin)) r.xmin = 10'(x);
                    if (x > int'(r.xmax)) r.xmax = 10'(x);
                    if (y < int'(r.ymin)) r.ymin = 10'(y);
                    if (y > int'(r.ymax)) r.ymax = 10'(y);
                end
        r.valid = (r.cnt != 20'd0);
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && frame_done) begin
            n_done++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL frame_done_unexpected: got pulse, expected none");
            end else begin
                mon_r = sb.pop_front();
                check("hit_cnt",    32'(hit_cnt),    32'(mon_r.cnt));
                check("bbox_x_min", 32'(bbox_x_min), 32'(mon_r.xmin));
                check("bbox_x_max", 32'(bbox_x_max), 32'(mon_r.xmax));
                check("bbox_y_min", 32'(bbox_y_min), 32'(mon_r.ymin));
                check("bbox_y_max", 32'(bbox_y_max), 32'(mon_r.ymax));
                check("bbox_valid", 32'(bbox_valid), 32'(mon_r.valid));
            end
        end
    end

    task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
        cfg_wr_en = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_wr_en = 1'b0;
    endtask

    // Optional write lands in the commit cycle (second cycle of vsync high).
    task automatic vsync_pulse(input logic commit_wr, input logic [2:0] a, input logic [7:0] d);
        per_frame_vsync = 1'b1;
        @(negedge clk);
        if (commit_wr) begin
            cfg_wr_en = 1'b1; cfg_addr = a; cfg_wdata = d;
        end
        @(negedge clk);
        cfg_wr_en = 1'b0;
        @(negedge clk);
        per_frame_vsync = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic body(input int mode, input int ax, input int ay, input int bx, input int by,
                        input logic wr, input logic [2:0] a, input logic [7:0] d,
                        input logic push, input int nlines);
        for (int y = 0; y < nlines; y++) begin
            for (int x = 0; x < 16; x++) begin
                per_frame_href  = 1'b1;
                per_frame_clken = 1'b1;
                mask_in = is_hit(mode, ax, ay, bx, by, x, y);
                if (wr && y == 3 && x == 0) begin
                    cfg_wr_en = 1'b1; cfg_addr = a; cfg_wdata = d;
                end else begin
                    cfg_wr_en = 1'b0;
                end
                @(negedge clk);
            end
            per_frame_href = 1'b0; per_frame_clken = 1'b0; mask_in = 1'b0; cfg_wr_en = 1'b0;
            repeat (4) @(negedge clk);
        end
        if (push) sb.push_back(model(mode, ax, ay, bx, by));
    endtask

    task automatic check_thresh(input string tag);
        check({tag, "_cb_min"}, 32'(cb_min), 32'(cur_cbmin));
        check({tag, "_cb_max"}, 32'(cb_max), 32'(cur_cbmax));
        check({tag, "_cr_min"}, 32'(cr_min), 32'(cur_crmin));
        check({tag, "_cr_max"}, 32'(cr_max), 32'(cur_crmax));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_thresh(tag);
        check({tag, "_cfg_pending"}, 32'(cfg_pending), 32'd0);
        check({tag, "_hit_cnt"},     32'(hit_cnt),     32'd0);
        check({tag, "_bbox_valid"},  32'(bbox_valid),  32'd0);
        check({tag, "_bbox_x_min"},  32'(bbox_x_min),  32'd1023);
        check({tag, "_bbox_x_max"},  32'(bbox_x_max),  32'd0);
        check({tag, "_bbox_y_min"},  32'(bbox_y_min),  32'd1023);
        check({tag, "_bbox_y_max"},  32'(bbox_y_max),  32'd0);
        check({tag, "_frame_done"},  32'(frame_done),  32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_fail = 0; n_done = 0;
        cur_cbmin = 8'd179; cur_cbmax = 8'd255; cur_crmin = 8'd97; cur_crmax = 8'd108;
        vecs[0] = '{2,  3, 2, 10, 5, 3'd0, 8'd77,  8'd77, 8'd255, 8'd97,  8'd108};
        vecs[1] = '{1,  0, 0,  0, 0, 3'd1, 8'd200, 8'd77, 8'd200, 8'd97,  8'd108};
        vecs[2] = '{2, 15, 0,  0, 7, 3'd2, 8'd130, 8'd77, 8'd200, 8'd130, 8'd108};
        vecs[3] = '{3,  0, 0,  0, 0, 3'd3, 8'd140, 8'd77, 8'd200, 8'd130, 8'd140};
        vecs[4] = '{0,  0, 0,  0, 0, 3'd5, 8'd9,   8'd77, 8'd200, 8'd130, 8'd140};
        vecs[5] = '{1,  7, 4,  0, 0, 3'd4, 8'hFF,  8'd77, 8'd200, 8'd130, 8'd140};
        vecs[6] = '{2,  2, 6,  9, 1, 3'd7, 8'd1,   8'd77, 8'd200, 8'd130, 8'd140};

        rst_n = 1'b0; cfg_wr_en = 1'b0; cfg_addr = 3'd0; cfg_wdata = 8'd0;
        per_frame_vsync = 1'b0; per_frame_href = 1'b0; per_frame_clken = 1'b0; mask_in = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Enable, partial first frame, then two empty frames
        cfg_write(3'd4, 8'd1);
        repeat (3) @(negedge clk);
        vsync_pulse(1'b0, 3'd0, 8'd0);
        check("wait_commit_no_done", 32'(n_done), 32'd0);
        body(0, 0, 0, 0, 0, 1'b0, 3'd0, 8'd0, 1'b1, 8);
        vsync_pulse(1'b0, 3'd0, 8'd0);
        body(0, 0, 0, 0, 0, 1'b0, 3'd0, 8'd0, 1'b1, 8);
        vsync_pulse(1'b0, 3'd0, 8'd0);
        check("empty_frames_done", 32'(n_done), 32'd2);

        // Table of frames, each with a mid-frame register write
        for (int i = 0; i < 7; i++) begin
            body(vecs[i].mode, vecs[i].ax, vecs[i].ay, vecs[i].bx, vecs[i].by,
                 1'b1, vecs[i].addr, vecs[i].data, 1'b1, 8);
            check("mid_pending", 32'(cfg_pending), 32'(vecs[i].addr <= 3'd3));
            check_thresh("mid");
            vsync_pulse(1'b0, 3'd0, 8'd0);
            cur_cbmin = vecs[i].e_cbmin; cur_cbmax = vecs[i].e_cbmax;
            cur_crmin = vecs[i].e_crmin; cur_crmax = vecs[i].e_crmax;
            check_thresh("commit");
            check("commit_pending", 32'(cfg_pending), 32'd0);
        end
        check("table_done_count", 32'(n_done), 32'd9);

        // Write in the exact commit cycle applies one frame later
        body(0, 0, 0, 0, 0, 1'b0, 3'd0, 8'd0, 1'b1, 8);
        vsync_pulse(1'b1, 3'd3, 8'd150);
        check("commit_wr_cr_max", 32'(cr_max), 32'(cur_crmax));
        check("commit_wr_pending", 32'(cfg_pending), 32'd1);
        body(0, 0, 0, 0, 0, 1'b0, 3'd0, 8'd0, 1'b1, 8);
        vsync_pulse(1'b0, 3'd0, 8'd0);
        cur_crmax = 8'd150;
        check("late_cr_max", 32'(cr_max), 32'd150);
        check("late_pending", 32'(cfg_pending), 32'd0);

        // Disable mid-frame: results held, no frame_done until a full frame after re-enable
        body(2, 3, 2, 10, 5, 1'b0, 3'd0, 8'd0, 1'b1, 8);
        vsync_pulse(1'b0, 3'd0, 8'd0);
        done_ref = n_done;
        body(1, 5, 1, 0, 0, 1'b1, 3'd4, 8'd0, 1'b0, 5);
        repeat (10) @(negedge clk);
        check("dis_hit_cnt", 32'(hit_cnt), 32'd2);
        check("dis_bbox_valid", 32'(bbox_valid), 32'd1);
        vsync_pulse(1'b0, 3'd0, 8'd0);
        check("dis_no_done", 32'(n_done), 32'(done_ref));
        check_thresh("dis");
        cfg_write(3'd4, 8'd1);
        repeat (3) @(negedge clk);
        vsync_pulse(1'b0, 3'd0, 8'd0);
        check("reen_no_done", 32'(n_done), 32'(done_ref));
        check("reen_hit_cnt", 32'(hit_cnt), 32'd2);
        body(1, 6, 3, 0, 0, 1'b0, 3'd0, 8'd0, 1'b1, 8);
        vsync_pulse(1'b0, 3'd0, 8'd0);
        check("reen_done", 32'(n_done), 32'(done_ref + 1));

        // Reset mid-frame with a pending write
        body(2, 1, 1, 4, 2, 1'b1, 3'd0, 8'd5, 1'b0, 4);
        check("pre_rst_pending", 32'(cfg_pending), 32'd1);
        rst_n = 1'b0;
        #1;
        cur_cbmin = 8'd179; cur_cbmax = 8'd255; cur_crmin = 8'd97; cur_crmax = 8'd108;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        done_ref = n_done;
        cfg_write(3'd4, 8'd1);
        repeat (3) @(negedge clk);
        vsync_pulse(1'b0, 3'd0, 8'd0);
        check("rst_wait_no_done", 32'(n_done), 32'(done_ref));
        check_thresh("rst_commit");
        body(2, 1, 1, 4, 6, 1'b0, 3'd0, 8'd0, 1'b1, 8);
        vsync_pulse(1'b0, 3'd0, 8'd0);
        check("rst_full_done", 32'(n_done), 32'(done_ref + 1));

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
